// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fulladder.sv
// One-bit full adder; the only arithmetic cell used by the serial subtractor.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);

    assign sum       = a ^ b ^ carry_in;
    assign carry_out = (a & b) | (a & carry_in) | (b & carry_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b computed as a + ~b + 1, one bit per clock, LSB first,
// through a single full adder whose carry is held in one flip-flop.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sr;
    logic             cy;
    logic [CNT_W-1:0] cnt;
    logic             a_msb;
    logic             b_msb;

    logic fa_b;
    logic fa_sum;
    logic fa_cout;

    assign fa_b = ~sb[0];

    fulladder u_fulladder (
        .a         (sa[0]),
        .b         (fa_b),
        .carry_in  (cy),
        .sum       (fa_sum),
        .carry_out (fa_cout)
    );

    // Operand sign bits are shifted out during RUN, so they are kept aside
    // for the signed-overflow decision made in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            sa       <= '0;
            sb       <= '0;
            sr       <= '0;
            cy       <= 1'b0;
            cnt      <= '0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            diff     <= '0;
            borrow   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register here sample
            // the pre-edge values, so the shift and the carry update line up.
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        cy    <= 1'b1;
                        cnt   <= '0;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sa  <= {1'b0, sa[WIDTH-1:1]};
                    sb  <= {1'b0, sb[WIDTH-1:1]};
                    sr  <= {fa_sum, sr[WIDTH-1:1]};
                    cy  <= fa_cout;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    diff     <= sr;
                    borrow   <= ~cy;
                    overflow <= (a_msb != b_msb) && (sr[WIDTH-1] != a_msb);
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8): latency, results, start
// masking, mid-operation reset, back-to-back starts and a reference sweep.
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow;
    logic       overflow;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .diff     (diff),
        .borrow   (borrow),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Returns with the bench sitting in the done cycle (or after the bound).
    task automatic wait_done(output int lat, output int busy_n);
        lat    = 0;
        busy_n = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busy_n++;
            @(negedge clk);
            lat++;
        end
        if (done !== 1'b1) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [7:0] op_a, input logic [7:0] op_b,
                          input logic [7:0] exp_d, input logic exp_bo, input logic exp_ov);
        int lat, busy_n;
        @(negedge clk);
        start = 1'b1; a = op_a; b = op_b;
        @(negedge clk);
        start = 1'b0; a = 8'($urandom); b = 8'($urandom);
        wait_done(lat, busy_n);
        check({tag, "_latency"}, 32'(lat), 32'd9);
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'd9);
        check({tag, "_diff"}, 32'(diff), 32'(exp_d));
        check({tag, "_borrow"}, 32'(borrow), 32'(exp_bo));
        check({tag, "_overflow"}, 32'(overflow), 32'(exp_ov));
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int lat, busy_n, n_done, c_prev;
        logic [7:0] ra, rb, rd;
        logic [7:0] bb_a [3];
        logic [7:0] bb_b [3];
        logic [7:0] bb_d [3];
        logic       bb_bo [3];
        logic       bb_ov [3];

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_outputs", {29'd0, borrow, overflow, |diff}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("sub_05_03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        run_op("sub_00_01", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
        run_op("sub_80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        run_op("sub_7f_ff", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
        run_op("sub_aa_aa", 8'hAA, 8'hAA, 8'h00, 1'b0, 1'b0);
        run_op("sub_01_80", 8'h01, 8'h80, 8'h81, 1'b1, 1'b1);
        run_op("sub_ff_01", 8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0);

        // Start pulsed mid-RUN with other operands must be ignored.
        @(negedge clk);
        start = 1'b1; a = 8'h33; b = 8'h11;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; a = 8'h01; b = 8'h02;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, busy_n);
        check("midrun_latency", 32'(lat + 4), 32'd9);
        check("midrun_diff", 32'(diff), 32'h22);
        check("midrun_borrow", 32'(borrow), 32'd0);
        n_done = 0;
        repeat (15) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        check("midrun_no_second_done", 32'(n_done), 32'd0);
        check("midrun_idle", 32'(busy), 32'd0);

        // Asynchronous reset in the fourth RUN cycle.
        @(negedge clk);
        start = 1'b1; a = 8'h80; b = 8'h01;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_outputs", {28'd0, done, borrow, overflow, |diff}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        check("midrst_no_done", 32'(n_done), 32'd0);
        check("midrst_diff_held", 32'(diff), 32'd0);
        run_op("after_rst_10_01", 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0);

        // Start held high: three operations, done every 10 cycles.
        bb_a = '{8'h10, 8'hC8, 8'h50};
        bb_b = '{8'h20, 8'h37, 8'hB0};
        bb_d = '{8'hF0, 8'h91, 8'hA0};
        bb_bo = '{1'b1, 1'b0, 1'b1};
        bb_ov = '{1'b0, 1'b0, 1'b1};
        @(negedge clk);
        start = 1'b1; a = bb_a[0]; b = bb_b[0];
        @(negedge clk);
        c_prev = cyc;
        for (int k = 0; k < 3; k++) begin
            wait_done(lat, busy_n);
            check($sformatf("b2b%0d_spacing", k), 32'(cyc - c_prev), (k == 0) ? 32'd9 : 32'd10);
            check($sformatf("b2b%0d_diff", k), 32'(diff), 32'(bb_d[k]));
            check($sformatf("b2b%0d_borrow", k), 32'(borrow), 32'(bb_bo[k]));
            check($sformatf("b2b%0d_overflow", k), 32'(overflow), 32'(bb_ov[k]));
            c_prev = cyc;
            if (k < 2) begin
                a = bb_a[k+1]; b = bb_b[k+1];
                @(negedge clk);
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        check("b2b_done_pulse", 32'(done), 32'd0);
        check("b2b_stopped", 32'(busy), 32'd0);

        // Reference sweep.
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rd = ra - rb;
            run_op($sformatf("rand%0d", i), ra, rb, rd, ra < rb,
                   (ra[7] != rb[7]) && (rd[7] != ra[7]));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
